// File: rtl/uart_cmd_parser.sv
// Command-frame parser behind uart_rx: HEAD, CMD, DH, DL[, CHK] -> registered cmd/cmd_data strobe.
// Optional checksum byte enabled by defining UART_CMD_CHECKSUM_EN.
module uart_cmd_parser #(
    parameter logic [7:0]  HEAD    = 8'h55,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic        din_vld,
    output logic [7:0]  cmd,
    output logic [15:0] cmd_data,
    output logic        cmd_vld,
    output logic        err
);

    localparam int unsigned CNT_W = 26;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S_CMD = 3'd1,
        S_DH  = 3'd2,
`ifdef UART_CMD_CHECKSUM_EN
        S_DL  = 3'd3,
        S_CHK = 3'd4
`else
        S_DL  = 3'd3
`endif
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       sh_cmd;
    logic [7:0]       sh_dh;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]       sh_dl;
    logic             cap_dl_c;
`endif

    logic tmo_c;
    logic cap_cmd_c;
    logic cap_dh_c;
    logic load_c;
    logic err_c;

    // A byte arriving in the expiry cycle wins over the timeout.
    assign tmo_c = (state != IDLE) && !din_vld && (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (tmo_c) begin
            state_nxt = IDLE;
        end else if (din_vld) begin
            case (state)
                IDLE:    state_nxt = (din == HEAD) ? S_CMD : IDLE;
                S_CMD:   state_nxt = S_DH;
                S_DH:    state_nxt = S_DL;
`ifdef UART_CMD_CHECKSUM_EN
                S_DL:    state_nxt = S_CHK;
                S_CHK:   state_nxt = IDLE;
`else
                S_DL:    state_nxt = IDLE;
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output / capture decode
    always_comb begin
        cap_cmd_c = 1'b0;
        cap_dh_c  = 1'b0;
        load_c    = 1'b0;
        err_c     = tmo_c;
`ifdef UART_CMD_CHECKSUM_EN
        cap_dl_c  = 1'b0;
`endif
        if (din_vld) begin
            case (state)
                S_CMD: cap_cmd_c = 1'b1;
                S_DH:  cap_dh_c  = 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
                S_DL:  cap_dl_c  = 1'b1;
                S_CHK: begin
                    if (din == (sh_cmd ^ sh_dh ^ sh_dl)) begin
                        load_c = 1'b1;
                    end else begin
                        err_c  = 1'b1;
                    end
                end
`else
                S_DL:  load_c    = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // Inter-byte timeout counter, idle while waiting for a header
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (din_vld || (state == IDLE) || tmo_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Shadow registers; a timed-out partial frame is discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_cmd <= '0;
            sh_dh  <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            sh_dl  <= '0;
`endif
        end else if (tmo_c) begin
            sh_cmd <= '0;
            sh_dh  <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            sh_dl  <= '0;
`endif
        end else begin
            if (cap_cmd_c) sh_cmd <= din;
            if (cap_dh_c)  sh_dh  <= din;
`ifdef UART_CMD_CHECKSUM_EN
            if (cap_dl_c)  sh_dl  <= din;
`endif
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd      <= '0;
            cmd_data <= '0;
            cmd_vld  <= 1'b0;
            err      <= 1'b0;
        end else begin
            cmd_vld <= load_c;
            err     <= err_c;
            if (load_c) begin
                cmd      <= sh_cmd;
`ifdef UART_CMD_CHECKSUM_EN
                cmd_data <= {sh_dh, sh_dl};
`else
                cmd_data <= {sh_dh, din};
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser (TIMEOUT=20); frame length follows UART_CMD_CHECKSUM_EN.
module tb_uart_cmd_parser;

    localparam logic [7:0] HEAD = 8'h55;
    localparam int unsigned TMO = 20;
`ifdef UART_CMD_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_vld;
    logic [7:0]  cmd;
    logic [15:0] cmd_data;
    logic        cmd_vld;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int vld_cnt  = 0;
    int err_cnt  = 0;

    uart_cmd_parser #(.HEAD(HEAD), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
        .cmd(cmd), .cmd_data(cmd_data), .cmd_vld(cmd_vld), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] bytes;   // byte i at bits [63-8*i -: 8]
        int          n;
        logic [7:0]  exp_cmd;
        logic [15:0] exp_data;
        logic        exp_vld;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Pulse monitor: strobes counted, never both at once
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_vld) vld_cnt++;
            if (err)     err_cnt++;
            if (cmd_vld || err) check("vld_err_exclusive", 32'(cmd_vld & err), 32'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b, output logic v, output logic e);
        @(negedge clk);
        din     = b;
        din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
        v = cmd_vld;
        e = err;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] dh, input logic [7:0] dl,
                              output logic v, output logic e);
        send_byte(HEAD, v, e);
        send_byte(c, v, e);
        send_byte(dh, v, e);
        send_byte(dl, v, e);
        if (CHK_EN) send_byte(c ^ dh ^ dl, v, e);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic v, e, early;
        int   v0, e0, err_at, err_seen;

`ifdef UART_CMD_CHECKSUM_EN
        vecs[0] = '{64'h5501123427_000000, 5, 8'h01, 16'h1234, 1'b1, 1'b0};
        vecs[1] = '{64'h5501123400_000000, 5, 8'h01, 16'h1234, 1'b0, 1'b1};
        vecs[2] = '{64'h5502006466_000000, 5, 8'h02, 16'h0064, 1'b1, 1'b0};
        vecs[3] = '{64'hAA005503ABCD6500, 7, 8'h03, 16'hABCD, 1'b1, 1'b0};
        vecs[4] = '{64'h5555555555_000000, 5, 8'h55, 16'h5555, 1'b1, 1'b0};
        vecs[5] = '{64'h55FF0001FE_000000, 5, 8'hFF, 16'h0001, 1'b1, 1'b0};
`else
        vecs[0] = '{64'h55011234_00000000, 4, 8'h01, 16'h1234, 1'b1, 1'b0};
        vecs[1] = '{64'h2755020064_000000, 5, 8'h02, 16'h0064, 1'b1, 1'b0};
        vecs[2] = '{64'hAA005503ABCD_0000, 6, 8'h03, 16'hABCD, 1'b1, 1'b0};
        vecs[3] = '{64'h55555555_00000000, 4, 8'h55, 16'h5555, 1'b1, 1'b0};
        vecs[4] = '{64'h55A55AC3_00000000, 4, 8'hA5, 16'h5AC3, 1'b1, 1'b0};
        vecs[5] = '{64'h55FF0001_00000000, 4, 8'hFF, 16'h0001, 1'b1, 1'b0};
`endif

        rst_n   = 1'b0;
        din     = 8'h00;
        din_vld = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {6'd0, cmd_vld, err, cmd, cmd_data}, 32'd0);
        rst_n = 1'b1;

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            logic [63:0] bs;
            bs    = vecs[i].bytes;
            early = 1'b0;
            v0 = vld_cnt;
            e0 = err_cnt;
            for (int j = 0; j < vecs[i].n; j++) begin
                send_byte(bs[63 - 8*j -: 8], v, e);
                if (j < vecs[i].n - 1) early = early | v | e;
            end
            check($sformatf("v%0d_early_pulse", i), 32'(early), 32'd0);
            check($sformatf("v%0d_cmd_vld", i), 32'(v), 32'(vecs[i].exp_vld));
            check($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_cmd", i), 32'(cmd), 32'(vecs[i].exp_cmd));
            check($sformatf("v%0d_cmd_data", i), 32'(cmd_data), 32'(vecs[i].exp_data));
            settle();
            check($sformatf("v%0d_vld_pulses", i), 32'(vld_cnt - v0), 32'(vecs[i].exp_vld));
            check($sformatf("v%0d_err_pulses", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
        end

        // Macro-off tail byte after a 4-byte frame is ignored in IDLE
        v0 = vld_cnt;
        e0 = err_cnt;
        send_byte(8'h27, v, e);
        settle();
        check("stray_byte_pulses", 32'((vld_cnt - v0) + (err_cnt - e0)), 32'd0);

        // Inter-byte timeout: err exactly TMO cycles after the last byte
        v0 = vld_cnt;
        err_at   = -1;
        err_seen = 0;
        send_byte(HEAD, v, e);
        send_byte(8'h01, v, e);
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (err) begin
                err_at = i;
                err_seen++;
            end
        end
        check("tmo_err_cycle", 32'(err_at), 32'(TMO));
        check("tmo_err_count", 32'(err_seen), 32'd1);
        check("tmo_no_vld", 32'(vld_cnt - v0), 32'd0);
        check("tmo_cmd_held", 32'(cmd), 32'hFF);
        send_frame(8'h01, 8'h12, 8'h34, v, e);
        check("post_tmo_vld", 32'(v), 32'd1);
        check("post_tmo_data", {8'd0, cmd, cmd_data}, 32'h0001_1234);

        // Byte arriving in the expiry cycle wins
        settle();
        e0 = err_cnt;
        send_byte(HEAD, v, e);
        repeat (18) @(negedge clk);
        send_byte(8'h0A, v, e);
        send_byte(8'hBE, v, e);
        send_byte(8'hEF, v, e);
        if (CHK_EN) send_byte(8'h0A ^ 8'hBE ^ 8'hEF, v, e);
        check("race_vld", 32'(v), 32'd1);
        check("race_data", {8'd0, cmd, cmd_data}, 32'h000A_BEEF);
        settle();
        check("race_no_err", 32'(err_cnt - e0), 32'd0);

        // One cycle later the timeout wins and the rest of the frame is dropped
        e0 = err_cnt;
        v0 = vld_cnt;
        send_byte(HEAD, v, e);
        repeat (19) @(negedge clk);
        send_byte(8'h0B, v, e);
        send_byte(8'hBE, v, e);
        send_byte(8'hEF, v, e);
        if (CHK_EN) send_byte(8'h0B ^ 8'hBE ^ 8'hEF, v, e);
        settle();
        check("late_err", 32'(err_cnt - e0), 32'd1);
        check("late_no_vld", 32'(vld_cnt - v0), 32'd0);
        check("late_cmd_held", {8'd0, cmd, cmd_data}, 32'h000A_BEEF);

        // Reset mid-frame
        send_byte(HEAD, v, e);
        send_byte(8'h01, v, e);
        send_byte(8'h12, v, e);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", {6'd0, cmd_vld, err, cmd, cmd_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v0 = vld_cnt;
        e0 = err_cnt;
        send_byte(8'h34, v, e);
        send_byte(8'h27, v, e);
        settle();
        check("midrst_tail_ignored", 32'((vld_cnt - v0) + (err_cnt - e0)), 32'd0);
        check("midrst_cmd_zero", {8'd0, cmd, cmd_data}, 32'd0);
        send_frame(8'h3C, 8'h12, 8'h34, v, e);
        check("midrst_frame_vld", 32'(v), 32'd1);
        check("midrst_frame_data", {8'd0, cmd, cmd_data}, 32'h003C_1234);
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
